// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared stage structs and constants for the pipeline-stage
//               register. Callers pack their fields through these structs.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

   // EX/MEM payload: pc, ALU result, rs2 value and instruction word
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_result;
      logic [31:0] rs2;
      logic [31:0] inst;
   } ex_mem_data_t;

   // EX/MEM control: memory and write-back controls, padded to 16 bits
   typedef struct packed {
      logic       memr;
      logic       memw;
      logic [2:0] mem_ctrl;
      logic [1:0] wb_sel;
      logic       reg_wen;
      logic [7:0] rsvd;
   } ex_mem_ctrl_t;

   localparam int EX_MEM_DATA_W  = $bits(ex_mem_data_t);
   localparam int EX_MEM_CTRL_W  = $bits(ex_mem_ctrl_t);
   localparam int SIDE_DELAY_MAX = 4;
   localparam int CNT_W          = 32;

endpackage
`default_nettype wire

// File: rtl/pipe_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : pipe_delay_line
// Description : Enable-gated shift line of DEPTH stages for sideband bits.
//               Newest sample sits in the low slice, output is the oldest.
//               Clear has priority over enable.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_delay_line #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH*WIDTH-1:0] line;

   if (DEPTH == 1) begin : g_single
      // Single stage: load the input whenever enabled
      always_ff @(posedge clk) begin
         if (rst || clr) begin
            line <= '0;
         end else if (en) begin
            line <= din;
         end
      end
   end else begin : g_multi
      // Multi stage: shift towards the MSB end and load the input at the LSB end
      always_ff @(posedge clk) begin
         if (rst || clr) begin
            line <= '0;
         end else if (en) begin
            line <= {line[(DEPTH-1)*WIDTH-1:0], din};
         end
      end
   end

   assign dout = line[DEPTH*WIDTH-1 -: WIDTH];

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic handshaked pipeline-stage register. It has a main
//               register (M) driving the outputs and a one-entry skid register
//               (S). It also handles stall/flush and carries a sideband delay
//               line of SIDE_DELAY+1 stages (legal SIDE_DELAY: 0..4).
//               Optional macro PIPE_STAGE_PERF_CNT_EN adds saturating
//               stall/flush/backpressure counters.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W     = EX_MEM_DATA_W,
   parameter int CTRL_W     = EX_MEM_CTRL_W,
   parameter int SIDE_W     = 2,
   parameter int SIDE_DELAY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [SIDE_W-1:0] in_side,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [SIDE_W-1:0] out_side
`ifdef PIPE_STAGE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic [CNT_W-1:0]  bp_cnt
`endif
);

   localparam int SIDE_DEPTH = SIDE_DELAY + 1;

   logic              live;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic [CTRL_W-1:0] m_ctrl;
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic [CTRL_W-1:0] s_ctrl;

   logic in_fire;
   logic out_fire;
   logic m_take;
   logic side_en;

   // Ready depends only on registered state plus stall/flush; never on out_ready.
   // 'live' holds ready low until the cycle after reset is released.
   assign in_ready  = live && !s_valid && !stall && !flush;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = m_valid && !stall;
   assign out_fire  = out_valid && out_ready;
   assign m_take    = !m_valid || out_fire;
   assign out_data  = m_data;
   assign out_ctrl  = m_ctrl;
   assign side_en   = !stall;

   // Main/skid register update: flush clears, stall freezes, else advance beats
   always_ff @(posedge clk) begin
      if (rst) begin
         live    <= 1'b0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_ctrl  <= '0;
         s_valid <= 1'b0;
         s_data  <= '0;
         s_ctrl  <= '0;
      end else begin
         live <= 1'b1;
         if (flush) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_ctrl  <= '0;
         end else if (!stall) begin
            if (m_take) begin
               if (s_valid) begin
                  // The older skid beat moves up first; in_ready was low so no new beat arrives
                  m_valid <= 1'b1;
                  m_data  <= s_data;
                  m_ctrl  <= s_ctrl;
                  s_valid <= 1'b0;
               end else if (in_fire) begin
                  m_valid <= 1'b1;
                  m_data  <= in_data;
                  m_ctrl  <= in_ctrl;
               end else begin
                  m_valid <= 1'b0;
               end
            end else if (in_fire) begin
               // M is blocked downstream: park the new beat in the skid entry
               s_valid <= 1'b1;
               s_data  <= in_data;
               s_ctrl  <= in_ctrl;
            end
         end
      end
   end

   pipe_delay_line #(
      .WIDTH (SIDE_W),
      .DEPTH (SIDE_DEPTH)
   ) u_side_line (
      .clk  (clk),
      .rst  (rst),
      .en   (side_en),
      .clr  (flush),
      .din  (in_side),
      .dout (out_side)
   );

`ifdef PIPE_STAGE_PERF_CNT_EN
   logic bp_evt;
   assign bp_evt = m_valid && !out_ready && !stall;

   // Saturating event counters, one cycle behind their events
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         bp_cnt    <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
         if (bp_evt && (bp_cnt != '1)) begin
            bp_cnt <= bp_cnt + 1'b1;
         end
      end
   end
`endif

endmodule
`default_nettype wire
